// File: rtl/write_data_buffer_pkg.sv
// Shared types and constants for the write data buffer.
// Byte lanes are packed {R_Even,G_Even,B_Even,R_Odd,G_Odd,B_Odd}.
package write_data_buffer_pkg;

  localparam int PIXEL_PAIR_W = 48;

  localparam int R_EVEN_LSB = 40;
  localparam int G_EVEN_LSB = 32;
  localparam int B_EVEN_LSB = 24;
  localparam int R_ODD_LSB  = 16;
  localparam int G_ODD_LSB  = 8;
  localparam int B_ODD_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_DONE  = 2'b10
  } wdb_state_t;

  function automatic logic [PIXEL_PAIR_W-1:0] pack_pair(
    input logic [7:0] r_e,
    input logic [7:0] g_e,
    input logic [7:0] b_e,
    input logic [7:0] r_o,
    input logic [7:0] g_o,
    input logic [7:0] b_o
  );
    logic [PIXEL_PAIR_W-1:0] p;
    p = '0;
    p[R_EVEN_LSB +: 8] = r_e;
    p[G_EVEN_LSB +: 8] = g_e;
    p[B_EVEN_LSB +: 8] = b_e;
    p[R_ODD_LSB  +: 8] = r_o;
    p[G_ODD_LSB  +: 8] = g_o;
    p[B_ODD_LSB  +: 8] = b_o;
    return p;
  endfunction

  function automatic logic [31:0] pair_byte_sum(
    input logic [PIXEL_PAIR_W-1:0] p
  );
    return 32'(p[R_EVEN_LSB +: 8]) + 32'(p[G_EVEN_LSB +: 8])
         + 32'(p[B_EVEN_LSB +: 8]) + 32'(p[R_ODD_LSB  +: 8])
         + 32'(p[G_ODD_LSB  +: 8]) + 32'(p[B_ODD_LSB  +: 8]);
  endfunction

endpackage

// File: rtl/write_frame_ram.sv
// 1W/1R synchronous frame RAM, read-before-write, registered read.
// Out-of-range reads return zero; out-of-range writes are ignored.
module write_frame_ram #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_W     = 48
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;
  logic              rd_ok;

  assign wr_ok = 32'(wr_addr) < DEPTH;
  assign rd_ok = 32'(rd_addr) < DEPTH;

  always_ff @(posedge clk) begin
    if (wr_en && wr_ok)
      mem[wr_addr[IDX_W-1:0]] <= wr_data;
  end

  // Both blocks sample mem before the NBA update: old data on collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en)
        rd_data <= rd_ok ? mem[rd_addr[IDX_W-1:0]] : '0;
    end
  end

endmodule

// File: rtl/write_data_buffer.sv
// Captures one frame of RGB pixel pairs bottom-up into a frame RAM.
// Optional WRITE_DATA_CHECKSUM_EN adds a 32-bit byte-sum output.
module write_data_buffer
  import write_data_buffer_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 768,
  parameter int IMAGE_HEIGHT = 512,
  parameter int ADDR_WIDTH   = 18
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    vertical_Pulse,
  input  logic                    horizontal_Pulse,
  input  logic [7:0]              data_R_Even,
  input  logic [7:0]              data_G_Even,
  input  logic [7:0]              data_B_Even,
  input  logic [7:0]              data_R_Odd,
  input  logic [7:0]              data_G_Odd,
  input  logic [7:0]              data_B_Odd,
  input  logic                    rd_En,
  input  logic [ADDR_WIDTH-1:0]   rd_Addr,
`ifdef WRITE_DATA_CHECKSUM_EN
  output logic [31:0]             frame_Checksum,
`endif
  output logic [PIXEL_PAIR_W-1:0] rd_Data,
  output logic                    rd_Valid,
  output logic                    write_Done,
  output logic                    frame_Abort,
  output logic                    extra_Pulse
);

  localparam int PAIRS = IMAGE_WIDTH / 2;
  localparam int DEPTH = PAIRS * IMAGE_HEIGHT;
  localparam int COL_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

  wdb_state_t state, state_nxt;

  logic [COL_W-1:0] col, col_nxt;
  logic [ROW_W-1:0] row, row_nxt;
  logic             vs_d;
  logic             vs_rise;
  logic             col_end;
  logic             last_pair;
  logic             wr_en;
  logic             done_set;
  logic             done_clr;
  logic             abort_set;
  logic             extra_set;

  logic [31:0]             row_base;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [PIXEL_PAIR_W-1:0] wr_data;

  assign vs_rise   = vertical_Pulse & ~vs_d;
  assign col_end   = col == COL_W'(PAIRS - 1);
  assign last_pair = col_end && (row == ROW_W'(IMAGE_HEIGHT - 1));

  // Row 0 is the top image row, stored last (BMP bottom-up)
  assign row_base = (32'(IMAGE_HEIGHT - 1) - 32'(row)) * 32'(PAIRS);
  assign wr_addr  = ADDR_WIDTH'(row_base + 32'(col));
  assign wr_data  = pack_pair(data_R_Even, data_G_Even, data_B_Even,
                              data_R_Odd, data_G_Odd, data_B_Odd);

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    wr_en     = 1'b0;
    done_set  = 1'b0;
    done_clr  = 1'b0;
    abort_set = 1'b0;
    extra_set = 1'b0;
    unique case (state)
      ST_IDLE, ST_WRITE: begin
        if (state == ST_WRITE && vs_rise) begin
          abort_set = 1'b1;
          state_nxt = ST_IDLE;
          col_nxt   = '0;
          row_nxt   = '0;
        end else if (horizontal_Pulse) begin
          wr_en = 1'b1;
          if (last_pair) begin
            state_nxt = ST_DONE;
            done_set  = 1'b1;
            col_nxt   = '0;
            row_nxt   = '0;
          end else begin
            state_nxt = ST_WRITE;
            if (col_end) begin
              col_nxt = '0;
              row_nxt = row + ROW_W'(1);
            end else begin
              col_nxt = col + COL_W'(1);
            end
          end
        end
      end
      ST_DONE: begin
        if (vs_rise) begin
          state_nxt = ST_IDLE;
          done_clr  = 1'b1;
          col_nxt   = '0;
          row_nxt   = '0;
        end else if (horizontal_Pulse) begin
          extra_set = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        col_nxt   = '0;
        row_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      col         <= '0;
      row         <= '0;
      vs_d        <= 1'b0;
      write_Done  <= 1'b0;
      frame_Abort <= 1'b0;
      extra_Pulse <= 1'b0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
      vs_d  <= vertical_Pulse;
      if (done_set)
        write_Done <= 1'b1;
      else if (done_clr)
        write_Done <= 1'b0;
      if (abort_set)
        frame_Abort <= 1'b1;
      if (extra_set)
        extra_Pulse <= 1'b1;
    end
  end

`ifdef WRITE_DATA_CHECKSUM_EN
  logic [31:0] pair_sum;

  assign pair_sum = wr_en ? pair_byte_sum(wr_data) : 32'd0;

  // A pair accepted on the vs_Rise cycle (IDLE only) opens the new sum
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      frame_Checksum <= '0;
    else if (vs_rise)
      frame_Checksum <= pair_sum;
    else
      frame_Checksum <= frame_Checksum + pair_sum;
  end
`endif

  write_frame_ram #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_W     (PIXEL_PAIR_W)
  ) u_ram (
    .clk      (clk),
    .rst_n    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_En),
    .rd_addr  (rd_Addr),
    .rd_data  (rd_Data),
    .rd_valid (rd_Valid)
  );

endmodule
